// File: rtl/dbus_demux_1x5_if.sv
// Purpose: bundles the core-side request/response and the shared target-side
//          bus of the 1-to-5 data-bus demux into one interface.
// Ports  : m_* = core request (valid/addr/we/wdata/wstrb) and response
//          (ready/rdata/err); s_* = one-hot target request, shared registered
//          address/control/data, per-target ready and packed read data.
//          'slave' is the demux view; 'master' is the core + targets view.
interface dbus_demux_1x5_if;
    logic         m_valid;
    logic [31:0]  m_addr;
    logic         m_we;
    logic [31:0]  m_wdata;
    logic [3:0]   m_wstrb;
    logic         m_ready;
    logic [31:0]  m_rdata;
    logic         m_err;
    logic [4:0]   s_valid;
    logic [31:0]  s_addr;
    logic         s_we;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic [4:0]   s_ready;
    logic [159:0] s_rdata;

    modport slave (
        input  m_valid, m_addr, m_we, m_wdata, m_wstrb, s_ready, s_rdata,
        output m_ready, m_rdata, m_err, s_valid, s_addr, s_we, s_wdata, s_wstrb
    );

    modport master (
        output m_valid, m_addr, m_we, m_wdata, m_wstrb, s_ready, s_rdata,
        input  m_ready, m_rdata, m_err, s_valid, s_addr, s_we, s_wdata, s_wstrb
    );
endinterface

// File: rtl/dbus_demux_1x5.sv
// Purpose: routes one core data request to one of five address-decoded targets
//          (ROM, RAM, UART, GPIO, timer) and returns one registered response.
// Latency: hit with immediate target ready -> m_ready 2 cycles after request;
//          unmapped -> 1 cycle; timeout -> TIMEOUT+1 cycles.
// Backpressure: request held by the core until m_ready; target stalls by
//          holding s_ready low, bounded by TIMEOUT (0 = wait forever).
// Ports: clk, rst_n (sync, active low), bus (dbus_demux_1x5_if.slave).
module dbus_demux_1x5 #(
    parameter logic [31:0] BASE0   = 32'h0000_0000,
    parameter logic [31:0] BASE1   = 32'h1000_0000,
    parameter logic [31:0] BASE2   = 32'h2000_0000,
    parameter logic [31:0] BASE3   = 32'h2000_1000,
    parameter logic [31:0] BASE4   = 32'h2000_2000,
    parameter logic [31:0] MASK0   = 32'hFFFF_0000,
    parameter logic [31:0] MASK1   = 32'hFFFF_0000,
    parameter logic [31:0] MASK2   = 32'hFFFF_F000,
    parameter logic [31:0] MASK3   = 32'hFFFF_F000,
    parameter logic [31:0] MASK4   = 32'hFFFF_F000,
    parameter int unsigned TIMEOUT = 255
) (
    input logic             clk,
    input logic             rst_n,
    dbus_demux_1x5_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [31:0] BASE_A [5] = '{BASE0, BASE1, BASE2, BASE3, BASE4};
    localparam logic [31:0] MASK_A [5] = '{MASK0, MASK1, MASK2, MASK3, MASK4};
    // Last counter value allowed in ACCESS before the request is abandoned.
    localparam logic [31:0] CNT_LAST = (TIMEOUT == 0) ? 32'd0 : TIMEOUT - 1;

    logic [1:0]  state_q,   state_d;
    logic [4:0]  s_valid_q, s_valid_d;
    logic [31:0] s_addr_q,  s_addr_d;
    logic        s_we_q,    s_we_d;
    logic [31:0] s_wdata_q, s_wdata_d;
    logic [3:0]  s_wstrb_q, s_wstrb_d;
    logic        m_ready_q, m_ready_d;
    logic [31:0] m_rdata_q, m_rdata_d;
    logic        m_err_q,   m_err_d;
    logic [31:0] cnt_q,     cnt_d;

    logic [4:0]  hit_vec;
    logic [4:0]  hit_oh;
    logic [31:0] sel_rdata;
    logic        sel_ready;

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < 5; i++) begin
            hit_vec[i] = ((bus.m_addr & MASK_A[i]) == BASE_A[i]);
        end
    end

    // Isolate the lowest set bit so overlapping regions resolve to the lowest index.
    assign hit_oh = hit_vec & (~hit_vec + 5'd1);

    // Only the selected target's ready and data are looked at; stray readies are masked.
    assign sel_ready = |(s_valid_q & bus.s_ready);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < 5; i++) begin
            if (s_valid_q[i]) begin
                sel_rdata = bus.s_rdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        s_valid_d = s_valid_q;
        s_addr_d  = s_addr_q;
        s_we_d    = s_we_q;
        s_wdata_d = s_wdata_q;
        s_wstrb_d = s_wstrb_q;
        m_ready_d = 1'b0;
        m_rdata_d = m_rdata_q;
        m_err_d   = m_err_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.m_valid) begin
                    s_addr_d  = bus.m_addr;
                    s_we_d    = bus.m_we;
                    s_wdata_d = bus.m_wdata;
                    s_wstrb_d = bus.m_wstrb;
                    cnt_d     = '0;
                    if (|hit_oh) begin
                        s_valid_d = hit_oh;
                        state_d   = ST_ACCESS;
                    end else begin
                        m_rdata_d = '0;
                        m_err_d   = 1'b1;
                        m_ready_d = 1'b1;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                // Ready is checked first so a completion on the last allowed cycle wins.
                if (sel_ready) begin
                    m_rdata_d = s_we_q ? 32'd0 : sel_rdata;
                    m_err_d   = 1'b0;
                    m_ready_d = 1'b1;
                    s_valid_d = '0;
                    state_d   = ST_RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    m_rdata_d = '0;
                    m_err_d   = 1'b1;
                    m_ready_d = 1'b1;
                    s_valid_d = '0;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                s_valid_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            s_valid_q <= '0;
            s_addr_q  <= '0;
            s_we_q    <= 1'b0;
            s_wdata_q <= '0;
            s_wstrb_q <= '0;
            m_ready_q <= 1'b0;
            m_rdata_q <= '0;
            m_err_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            s_valid_q <= s_valid_d;
            s_addr_q  <= s_addr_d;
            s_we_q    <= s_we_d;
            s_wdata_q <= s_wdata_d;
            s_wstrb_q <= s_wstrb_d;
            m_ready_q <= m_ready_d;
            m_rdata_q <= m_rdata_d;
            m_err_q   <= m_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.m_ready = m_ready_q;
    assign bus.m_rdata = m_rdata_q;
    assign bus.m_err   = m_err_q;
    assign bus.s_valid = s_valid_q;
    assign bus.s_addr  = s_addr_q;
    assign bus.s_we    = s_we_q;
    assign bus.s_wdata = s_wdata_q;
    assign bus.s_wstrb = s_wstrb_q;
endmodule

// File: tb/tb_dbus_demux_1x5.sv
module tb_dbus_demux_1x5;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Two instances see identical stimulus: one with TIMEOUT=4, one with timeout disabled.
    dbus_demux_1x5_if if4 ();
    dbus_demux_1x5_if if0 ();

    assign if0.m_valid = if4.m_valid;
    assign if0.m_addr  = if4.m_addr;
    assign if0.m_we    = if4.m_we;
    assign if0.m_wdata = if4.m_wdata;
    assign if0.m_wstrb = if4.m_wstrb;
    assign if0.s_ready = if4.s_ready;
    assign if0.s_rdata = if4.s_rdata;

    dbus_demux_1x5 #(.TIMEOUT(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    dbus_demux_1x5 #(.TIMEOUT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

    logic        obs0;
    logic        o_ready, o_err, o_swe;
    logic [31:0] o_rdata, o_saddr, o_swdata;
    logic [4:0]  o_svalid;
    logic [3:0]  o_swstrb;
    assign o_ready  = obs0 ? if0.m_ready : if4.m_ready;
    assign o_err    = obs0 ? if0.m_err   : if4.m_err;
    assign o_rdata  = obs0 ? if0.m_rdata : if4.m_rdata;
    assign o_svalid = obs0 ? if0.s_valid : if4.s_valid;
    assign o_saddr  = obs0 ? if0.s_addr  : if4.s_addr;
    assign o_swe    = obs0 ? if0.s_we    : if4.s_we;
    assign o_swdata = obs0 ? if0.s_wdata : if4.s_wdata;
    assign o_swstrb = obs0 ? if0.s_wstrb : if4.s_wstrb;

    // Memory map as address ranges.
    logic [31:0] rbase [5] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h2000_1000, 32'h2000_2000};
    logic [31:0] rsize [5] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000};

    function automatic int model_tgt(input logic [31:0] a);
        for (int i = 0; i < 5; i++) begin
            if (a - rbase[i] < rsize[i]) return i;
        end
        return -1;
    endfunction

    // Expected outcome of one request: response cycle, access cycles, error and data.
    task automatic model_exp(input logic [31:0] addr, input logic we, input int dly,
                             input int tmo, input logic [31:0] data,
                             output int lat, output int vcyc, output logic [4:0] oh,
                             output logic [31:0] rd, output logic err);
        int t;
        t = model_tgt(addr);
        oh = (t >= 0) ? 5'(1 << t) : 5'd0;
        if (t < 0) begin
            lat = 1; vcyc = 0; rd = 0; err = 1'b1;
        end else if (dly >= 0 && (tmo == 0 || dly < tmo)) begin
            lat = dly + 2; vcyc = dly + 1; rd = we ? 32'd0 : data; err = 1'b0;
        end else begin
            lat = tmo + 1; vcyc = tmo; rd = 0; err = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if4.m_valid = 1'b0;
        if4.s_ready = 5'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drives one request from an IDLE cycle and records what the observed DUT did.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int dly, input logic [4:0] stray,
                           output int lat, output int vcyc, output logic [4:0] vseen,
                           output logic [31:0] rd, output logic err, output logic stable);
        int t;
        logic [4:0] oh;
        t = model_tgt(addr);
        oh = (t >= 0) ? 5'(1 << t) : 5'd0;
        lat = -1; vcyc = 0; vseen = 0; rd = 0; err = 1'b0; stable = 1'b1;
        if4.m_valid = 1'b1; if4.m_addr = addr; if4.m_we = we;
        if4.m_wdata = wdata; if4.m_wstrb = wstrb;
        if4.s_ready = stray & ~oh;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                if4.m_addr  = ~addr;
                if4.m_wdata = ~wdata;
                if4.s_ready = (stray & ~oh) | ((dly >= 0 && cyc - 1 == dly) ? oh : 5'd0);
            end
            @(negedge clk);
            if (o_svalid != 5'd0) begin
                vcyc++;
                vseen |= o_svalid;
                if (o_saddr !== addr || o_swe !== we || o_swdata !== wdata || o_swstrb !== wstrb)
                    stable = 1'b0;
            end
            if (o_ready === 1'b1) begin
                lat = cyc; rd = o_rdata; err = o_err;
                break;
            end
        end
        @(posedge clk); #1;
        if4.m_valid = 1'b0;
        if4.s_ready = 5'd0;
    endtask

    int lat, vcyc, elat, evcyc;
    logic [4:0] vseen, eoh;
    logic [31:0] rd, erd;
    logic err, eerr, stable;

    task automatic test_reset();
        rst_n = 1'b0;
        if4.m_valid = 1'b1; if4.m_addr = 32'h1000_0000; if4.m_we = 1'b1;
        if4.m_wdata = 32'h1234_5678; if4.m_wstrb = 4'hF;
        if4.s_ready = 5'h1F; if4.s_rdata = {5{32'hFFFF_FFFF}};
        repeat (3) @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            obs0 = (k == 1);
            @(negedge clk);
            checks++;
            if ({o_ready, o_err, o_swe, o_svalid, o_swstrb} !== 12'd0 || o_rdata !== 0 ||
                o_saddr !== 0 || o_swdata !== 0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d got ready=%b err=%b we=%b valid=%b strb=%h rdata=%h addr=%h wdata=%h exp all zero",
                         k, o_ready, o_err, o_swe, o_svalid, o_swstrb, o_rdata, o_saddr, o_swdata);
            end
        end
        obs0 = 1'b0;
        #1 if4.m_valid = 1'b0; if4.s_ready = 5'd0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_read_ram();
        do_reset();
        obs0 = 1'b0;
        if4.s_rdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_0000};
        run_txn(32'h1000_0004, 1'b0, 32'h0, 4'h0, 0, 5'd0, lat, vcyc, vseen, rd, err, stable);
        checks++; if (lat !== 2) begin failures++; $display("FAIL ram_read_latency got=%0d exp=2", lat); end
        checks++; if (vseen !== 5'b00010 || vcyc !== 1) begin failures++; $display("FAIL ram_read_select got=%b/%0d exp=00010/1", vseen, vcyc); end
        checks++; if (rd !== 32'hDEAD_BEEF || err !== 1'b0) begin failures++; $display("FAIL ram_read_data got=%h err=%b exp=deadbeef err=0", rd, err); end
        // Response stays on the bus while idle, with no further strobe.
        if4.s_rdata = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (o_rdata !== 32'hDEAD_BEEF || o_ready !== 1'b0) begin
                failures++; $display("FAIL rdata_hold got=%h ready=%b exp=deadbeef ready=0", o_rdata, o_ready);
            end
        end
    endtask

    task automatic test_write_gpio();
        do_reset();
        obs0 = 1'b0;
        if4.s_rdata = {5{32'hCAFE_F00D}};
        run_txn(32'h2000_1008, 1'b1, 32'h0000_00A5, 4'b0001, 3, 5'd0, lat, vcyc, vseen, rd, err, stable);
        checks++; if (vseen !== 5'b01000 || vcyc !== 4) begin failures++; $display("FAIL gpio_write_select got=%b/%0d exp=01000/4", vseen, vcyc); end
        checks++; if (stable !== 1'b1) begin failures++; $display("FAIL gpio_write_stable got=%b exp=1", stable); end
        checks++; if (lat !== 5 || rd !== 0 || err !== 1'b0) begin failures++; $display("FAIL gpio_write_resp got lat=%0d rd=%h err=%b exp lat=5 rd=0 err=0", lat, rd, err); end
    endtask

    task automatic test_unmapped();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            obs0 = (k == 1);
            run_txn(32'h3000_0000, 1'b0, 32'h0, 4'h0, 0, 5'h1F, lat, vcyc, vseen, rd, err, stable);
            checks++;
            if (lat !== 1 || vseen !== 5'd0 || err !== 1'b1 || rd !== 0) begin
                failures++; $display("FAIL unmapped dut%0d got lat=%0d valid=%b err=%b rd=%h exp lat=1 valid=0 err=1 rd=0", k, lat, vseen, err, rd);
            end
        end
        obs0 = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        obs0 = 1'b0;
        run_txn(32'h2000_0000, 1'b0, 32'h0, 4'h0, -1, 5'd0, lat, vcyc, vseen, rd, err, stable);
        checks++; if (lat !== 5 || vcyc !== 4 || vseen !== 5'b00100) begin failures++; $display("FAIL timeout4 got lat=%0d vcyc=%0d valid=%b exp 5/4/00100", lat, vcyc, vseen); end
        checks++; if (err !== 1'b1 || rd !== 0) begin failures++; $display("FAIL timeout4_err got err=%b rd=%h exp err=1 rd=0", err, rd); end
        do_reset();
        obs0 = 1'b1;
        if4.s_rdata = {32'h0, 32'h0, 32'h5A5A_1234, 32'h0, 32'h0};
        run_txn(32'h2000_0000, 1'b0, 32'h0, 4'h0, 300, 5'd0, lat, vcyc, vseen, rd, err, stable);
        checks++; if (lat !== 302 || vcyc !== 301) begin failures++; $display("FAIL no_timeout_len got lat=%0d vcyc=%0d exp 302/301", lat, vcyc); end
        checks++; if (err !== 1'b0 || rd !== 32'h5A5A_1234) begin failures++; $display("FAIL no_timeout_resp got err=%b rd=%h exp err=0 rd=5a5a1234", err, rd); end
        obs0 = 1'b0;
    endtask

    task automatic test_stray_race();
        do_reset();
        obs0 = 1'b0;
        if4.s_rdata = {32'h4, 32'h3, 32'h2, 32'h600D_DA7A, 32'h0};
        run_txn(32'h1000_0100, 1'b0, 32'h0, 4'h0, -1, 5'b11101, lat, vcyc, vseen, rd, err, stable);
        checks++; if (lat !== 5 || err !== 1'b1 || vseen !== 5'b00010) begin failures++; $display("FAIL stray_ready got lat=%0d err=%b valid=%b exp 5/1/00010", lat, err, vseen); end
        do_reset();
        run_txn(32'h1000_0100, 1'b0, 32'h0, 4'h0, 3, 5'b11101, lat, vcyc, vseen, rd, err, stable);
        checks++; if (lat !== 5 || err !== 1'b0 || rd !== 32'h600D_DA7A) begin failures++; $display("FAIL ready_timeout_race got lat=%0d err=%b rd=%h exp 5/0/600dda7a", lat, err, rd); end
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        obs0 = 1'b0;
        if4.m_valid = 1'b1; if4.m_addr = 32'h2000_2004; if4.m_we = 1'b0; if4.s_ready = 5'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0; if4.m_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (if4.s_valid !== 5'd0 || if4.m_ready !== 1'b0 || if0.s_valid !== 5'd0 || if0.m_ready !== 1'b0) begin
                failures++; $display("FAIL reset_mid_access cyc%0d got valid=%b/%b ready=%b/%b exp 0", k, if4.s_valid, if0.s_valid, if4.m_ready, if0.m_ready);
            end
        end
        @(posedge clk); #1;
        if4.s_rdata = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0B0B_0010};
        run_txn(32'h0000_0010, 1'b0, 32'h0, 4'h0, 1, 5'd0, lat, vcyc, vseen, rd, err, stable);
        checks++; if (lat !== 3 || vseen !== 5'b00001 || err !== 1'b0 || rd !== 32'h0B0B_0010) begin failures++; $display("FAIL rom_after_reset got lat=%0d valid=%b err=%b rd=%h exp 3/00001/0/0b0b0010", lat, vseen, err, rd); end
    endtask

    task automatic test_random_back_to_back();
        logic [31:0] addr, wdata, data;
        logic [3:0]  wstrb;
        logic        we;
        logic [4:0]  stray;
        int          r, dly, t;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 5);
            if (r < 5) addr = rbase[r] + $urandom_range(0, rsize[r] - 1);
            else       addr = 32'h3000_0000 | ($urandom & 32'h0FFF_FFFF);
            we = 1'($urandom_range(0, 1));
            wdata = $urandom; wstrb = 4'($urandom_range(0, 15));
            stray = 5'($urandom_range(0, 31));
            if4.s_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom};
            dly = $urandom_range(0, 4);
            if (dly == 4) begin dly = -1; obs0 = 1'b0; end
            else obs0 = 1'($urandom_range(0, 1));
            t = model_tgt(addr);
            data = (t >= 0) ? if4.s_rdata[32*t +: 32] : 32'd0;
            model_exp(addr, we, dly, obs0 ? 0 : 4, data, elat, evcyc, eoh, erd, eerr);
            run_txn(addr, we, wdata, wstrb, dly, stray, lat, vcyc, vseen, rd, err, stable);
            checks++;
            if (lat !== elat || vcyc !== evcyc || vseen !== eoh || rd !== erd || err !== eerr || stable !== 1'b1) begin
                failures++;
                $display("FAIL random_txn%0d addr=%h we=%b dly=%0d got lat=%0d vc=%0d v=%b rd=%h err=%b st=%b exp lat=%0d vc=%0d v=%b rd=%h err=%b st=1",
                         n, addr, we, dly, lat, vcyc, vseen, rd, err, stable, elat, evcyc, eoh, erd, eerr);
            end
            // The no-timeout instance is left waiting after an abandoned request.
            if (dly < 0) do_reset();
        end
        obs0 = 1'b0;
    endtask

    initial begin
        obs0 = 1'b0;
        rst_n = 1'b0;
        if4.m_valid = 1'b0; if4.m_addr = '0; if4.m_we = 1'b0;
        if4.m_wdata = '0; if4.m_wstrb = '0; if4.s_ready = '0; if4.s_rdata = '0;
        test_reset();
        test_read_ram();
        test_write_gpio();
        test_unmapped();
        test_timeout();
        test_stray_race();
        test_reset_mid_access();
        test_random_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dbus_demux_1x5.md
Name: dbus_demux_1x5

Overview:
- Data-bus router in the rv32i_core load/store path: fans one core data request out to one of five memory-mapped targets, the reverse of the core's result-select fan-in.
- Targets: S0 ROM, S1 RAM, S2 UART, S3 GPIO, S4 timer.
- Decodes the address, drives a valid/ready handshake to the selected target and returns one registered response (read data, error) to the core.
- Unmapped addresses and timeouts terminate with an error response.

Parameters:
- BASE0..BASE4, defaults 32'h0000_0000 / 32'h1000_0000 / 32'h2000_0000 / 32'h2000_1000 / 32'h2000_2000: region base per target.
- MASK0..MASK4, defaults 32'hFFFF_0000 / 32'hFFFF_0000 / 32'hFFFF_F000 / 32'hFFFF_F000 / 32'hFFFF_F000: region match mask per target.
- TIMEOUT, default 255: maximum cycles in ACCESS before abort. 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- m_valid  in  1  core request valid; held until m_ready
- m_addr  in  32  byte address
- m_we  in  1  1=write, 0=read
- m_wdata  in  32  write data
- m_wstrb  in  4  byte enables
- m_ready  out  1  one-cycle response strobe
- m_rdata  out  32  read data, valid with m_ready
- m_err  out  1  error flag, valid with m_ready
- s_valid  out  5  one-hot target request
- s_addr  out  32  registered address, shared by all targets
- s_we  out  1  registered write enable, shared
- s_wdata  out  32  registered write data, shared
- s_wstrb  out  4  registered byte enables, shared
- s_ready  in  5  per-target completion
- s_rdata  in  160  target i read data on bits [32i+31:32i]

Behaviour:
- Reset: rst_n sampled low at a clk edge forces the following, all at 0: state IDLE, s_valid, m_ready, m_rdata, m_err, s_addr, s_we, s_wdata, s_wstrb, timeout counter. Reset mid-transaction aborts it silently; no response is issued.
- Decode: target i hits when (m_addr & MASKi) == BASEi. On overlapping hits the lowest index wins.
- IDLE:
  - m_ready=0.
  - On m_valid=1: register addr/we/wdata/wstrb onto the s_* buses and clear the counter.
  - Hit: next state ACCESS with s_valid one-hot on the hit index.
  - No hit: next state RESP with err=1, rdata=0.
- ACCESS:
  - Hold s_valid[i] and all s_* buses stable.
  - When s_ready[i]=1: capture s_rdata slice i into m_rdata (0 if s_we=1), set err=0, drop s_valid, go to RESP.
  - s_ready bits of non-selected targets are ignored.
  - Otherwise the counter increments. When TIMEOUT!=0 and the counter equals TIMEOUT-1 without a ready: drop s_valid, go to RESP with err=1, rdata=0.
  - Ready and timeout in the same cycle: ready wins.
- RESP: m_ready=1 for exactly one cycle with m_rdata/m_err. Next state IDLE; m_rdata/m_err hold until the next RESP.
- Throughput: a new request is accepted in the IDLE cycle after RESP, so back-to-back requests are spaced by at least one idle cycle.
- Latency:
  - Request sampled in cycle 0, s_ready=1 on first ACCESS cycle (cycle 1): m_ready in cycle 2.
  - Unmapped request: m_ready in cycle 1.
  - Timeout: m_ready in cycle TIMEOUT+1.
- m_addr changes while in ACCESS have no effect; registered copies are used.

Test Plan:
- Read hit RAM: m_addr=32'h1000_0004, s_ready[1] tied 1, s_rdata slice1=32'hDEAD_BEEF -> s_valid=5'b00010 for 1 cycle; m_ready in cycle 2, m_rdata=32'hDEAD_BEEF, m_err=0.
- Write GPIO with wait states: m_addr=32'h2000_1008, m_we=1, m_wdata=32'h0000_00A5, m_wstrb=4'b0001, s_ready[3] after 3 cycles -> s_valid=5'b01000 held 4 cycles with stable s_wdata/s_wstrb; m_ready one cycle, m_rdata=0, m_err=0.
- Unmapped: m_addr=32'h3000_0000 -> s_valid stays 0; m_ready in cycle 1, m_err=1, m_rdata=0.
- Timeout, TIMEOUT=4: read UART 32'h2000_0000, s_ready=0 -> s_valid[2]=1 for 4 cycles; m_ready in cycle 5, m_err=1. Repeat with TIMEOUT=0 and ready after 300 cycles -> m_err=0.
- Stray ready plus race: s_ready=5'b11101 while selecting S1 -> no completion. s_ready[i] asserted on the final timeout cycle -> m_err=0, data returned.
- Reset mid-ACCESS: drive rst_n=0 for 1 cycle during ACCESS to S4 -> next cycle s_valid=0, m_ready=0, state IDLE; a subsequent ROM read 32'h0000_0010 completes normally.
